// File: rtl/memory_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : memory_stage_pipe
// Brief    : MEM pipeline stage. Drives a req/ack data-memory port with sized,
//            aligned byte-lane access, extracts and extends loads, stalls the
//            M stage while an access is outstanding and registers results
//            into the M/W pipeline register.
//            Optional macro: MEM_STAGE_STALL_CNT_EN adds a saturating
//            stall-cycle counter on stall_cnt_o.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module memory_stage_pipe #(
    parameter int DW = 32,
    parameter int RW = 5
`ifdef MEM_STAGE_STALL_CNT_EN
    ,
    parameter int CW = 16
`endif
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_m_i,
    input  logic            reg_write_m_i,
    input  logic            mem_to_reg_m_i,
    input  logic            mem_read_m_i,
    input  logic            mem_write_m_i,
    input  logic [1:0]      mem_size_m_i,
    input  logic            mem_unsigned_m_i,
    input  logic [DW-1:0]   alu_out_m_i,
    input  logic [DW-1:0]   write_data_m_i,
    input  logic [RW-1:0]   write_reg_m_i,
    input  logic            flush_m_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [DW-1:0]   dmem_addr_o,
    output logic [DW-1:0]   dmem_wdata_o,
    output logic [DW/8-1:0] dmem_be_o,
    input  logic            dmem_ack_i,
    input  logic [DW-1:0]   dmem_rdata_i,
    output logic            stall_m_o,
    output logic            misalign_o,
    output logic            valid_w_o,
    output logic            reg_write_w_o,
    output logic            mem_to_reg_w_o,
    output logic [DW-1:0]   alu_out_w_o,
    output logic [DW-1:0]   read_data_w_o,
    output logic [RW-1:0]   write_reg_w_o
`ifdef MEM_STAGE_STALL_CNT_EN
    ,
    output logic [CW-1:0]   stall_cnt_o
`endif
);

    localparam int C_NB = DW / 8;
    localparam int C_OW = $clog2(C_NB);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t          r_state;
    logic            r_flushed;
    logic [DW-1:0]   r_alu;
    logic [DW-1:0]   r_wdata;
    logic [1:0]      r_size;
    logic            r_uns;
    logic            r_we;
    logic            r_regw;
    logic            r_m2r;
    logic [RW-1:0]   r_wreg;
    logic            r_misalign;

    logic            w_in_wait;
    logic [1:0]      w_size_eff;
    logic            w_aligned;
    logic            w_mem_access;
    logic            w_mem_op;
    logic            w_misalign;
    logic [DW-1:0]   w_sel_alu;
    logic [DW-1:0]   w_sel_wdata;
    logic [1:0]      w_sel_size;
    logic            w_sel_uns;
    logic            w_sel_we;
    logic            w_sel_regw;
    logic            w_sel_m2r;
    logic [RW-1:0]   w_sel_wreg;
    logic [C_OW-1:0] w_off;
    logic [C_NB-1:0] w_be_base;
    logic [DW-1:0]   w_wdata_rep;
    logic [DW-1:0]   w_sh;
    logic            w_sext;
    logic [DW-1:0]   w_ext8;
    logic [DW-1:0]   w_ext16;
    logic [DW-1:0]   w_ext32;
    logic [DW-1:0]   w_load;
    logic            w_req;
    logic            w_capture;

    assign w_in_wait = (r_state == S_WAIT);

    // A dword request on a 32-bit datapath degrades to a word access
    assign w_size_eff = ((DW == 32) && (mem_size_m_i == 2'd3)) ? 2'd2 : mem_size_m_i;

    // Natural-alignment check on the live M-stage address
    always_comb begin
        w_aligned = 1'b1;
        case (w_size_eff)
            2'd0:    w_aligned = 1'b1;
            2'd1:    w_aligned = ~alu_out_m_i[0];
            2'd2:    w_aligned = (alu_out_m_i[1:0] == 2'b00);
            default: w_aligned = (alu_out_m_i[2:0] == 3'b000);
        endcase
    end

    assign w_mem_access = valid_m_i & (mem_read_m_i | mem_write_m_i) & ~flush_m_i;
    assign w_mem_op     = w_mem_access & w_aligned;
    assign w_misalign   = ~w_in_wait & w_mem_access & ~w_aligned;

    // While waiting, the bus and the W capture run from the registered copy
    assign w_sel_alu   = w_in_wait ? r_alu   : alu_out_m_i;
    assign w_sel_wdata = w_in_wait ? r_wdata : write_data_m_i;
    assign w_sel_size  = w_in_wait ? r_size  : w_size_eff;
    assign w_sel_uns   = w_in_wait ? r_uns   : mem_unsigned_m_i;
    assign w_sel_we    = w_in_wait ? r_we    : mem_write_m_i;
    assign w_sel_regw  = w_in_wait ? r_regw  : reg_write_m_i;
    assign w_sel_m2r   = w_in_wait ? r_m2r   : mem_to_reg_m_i;
    assign w_sel_wreg  = w_in_wait ? r_wreg  : write_reg_m_i;
    assign w_off       = w_sel_alu[C_OW-1:0];

    // Lane mask by size and lane-replicated store data
    always_comb begin
        w_be_base   = '1;
        w_wdata_rep = w_sel_wdata;
        case (w_sel_size)
            2'd0: begin
                w_be_base   = C_NB'(1);
                w_wdata_rep = {C_NB{w_sel_wdata[7:0]}};
            end
            2'd1: begin
                w_be_base   = C_NB'(3);
                w_wdata_rep = {(C_NB/2){w_sel_wdata[15:0]}};
            end
            2'd2: begin
                w_be_base   = C_NB'(15);
                w_wdata_rep = {(C_NB/4){w_sel_wdata[31:0]}};
            end
            default: begin
                w_be_base   = '1;
                w_wdata_rep = w_sel_wdata;
            end
        endcase
    end

    // Bring the addressed lane(s) down to bit 0 before extension
    assign w_sh    = dmem_rdata_i >> {w_off, 3'b000};
    assign w_sext  = ~w_sel_uns;
    assign w_ext8  = {{(DW-8){w_sh[7] & w_sext}}, w_sh[7:0]};
    assign w_ext16 = {{(DW-16){w_sh[15] & w_sext}}, w_sh[15:0]};

    generate
        if (DW > 32) begin : g_ext32_wide
            assign w_ext32 = {{(DW-32){w_sh[31] & w_sext}}, w_sh[31:0]};
        end else begin : g_ext32_native
            assign w_ext32 = w_sh;
        end
    endgenerate

    // Pick the extended load value for the access size
    always_comb begin
        w_load = w_sh;
        case (w_sel_size)
            2'd0:    w_load = w_ext8;
            2'd1:    w_load = w_ext16;
            2'd2:    w_load = w_ext32;
            default: w_load = w_sh;
        endcase
    end

    // Bus and stall outputs; gating with rst_i drops them as soon as reset asserts
    assign w_req        = rst_i & (w_in_wait | w_mem_op);
    assign dmem_req_o   = w_req;
    assign dmem_we_o    = w_req & w_sel_we;
    assign dmem_be_o    = w_req ? (w_be_base << w_off) : '0;
    assign dmem_addr_o  = {w_sel_alu[DW-1:C_OW], {C_OW{1'b0}}};
    assign dmem_wdata_o = w_wdata_rep;
    assign stall_m_o    = rst_i & ~dmem_ack_i & (w_in_wait | w_mem_op);
    assign misalign_o   = r_misalign;

    // A result enters W on a completing access or a plain non-memory op
    assign w_capture = w_in_wait
                     ? (dmem_ack_i & ~flush_m_i & ~r_flushed)
                     : ((w_mem_op & dmem_ack_i) |
                        (valid_m_i & ~mem_read_m_i & ~mem_write_m_i & ~flush_m_i));

    // Request FSM: snapshot the access on entry to WAIT, track a flush while waiting
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= S_IDLE;
            r_flushed <= 1'b0;
            r_alu     <= '0;
            r_wdata   <= '0;
            r_size    <= 2'd0;
            r_uns     <= 1'b0;
            r_we      <= 1'b0;
            r_regw    <= 1'b0;
            r_m2r     <= 1'b0;
            r_wreg    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_flushed <= 1'b0;
                    if (w_mem_op && !dmem_ack_i) begin
                        r_state <= S_WAIT;
                        r_alu   <= alu_out_m_i;
                        r_wdata <= write_data_m_i;
                        r_size  <= w_size_eff;
                        r_uns   <= mem_unsigned_m_i;
                        r_we    <= mem_write_m_i;
                        r_regw  <= reg_write_m_i;
                        r_m2r   <= mem_to_reg_m_i;
                        r_wreg  <= write_reg_m_i;
                    end
                end
                S_WAIT: begin
                    if (dmem_ack_i) begin
                        r_state   <= S_IDLE;
                        r_flushed <= 1'b0;
                    end else if (flush_m_i) begin
                        r_flushed <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // M/W pipeline register: capture a result or insert a bubble
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_w_o      <= 1'b0;
            reg_write_w_o  <= 1'b0;
            mem_to_reg_w_o <= 1'b0;
            alu_out_w_o    <= '0;
            read_data_w_o  <= '0;
            write_reg_w_o  <= '0;
        end else if (w_capture) begin
            valid_w_o      <= 1'b1;
            reg_write_w_o  <= w_sel_regw;
            mem_to_reg_w_o <= w_sel_m2r;
            alu_out_w_o    <= w_sel_alu;
            read_data_w_o  <= w_load;
            write_reg_w_o  <= w_sel_wreg;
        end else begin
            valid_w_o      <= 1'b0;
            reg_write_w_o  <= 1'b0;
        end
    end

    // One-cycle pulse for a rejected misaligned access
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misalign;
        end
    end

`ifdef MEM_STAGE_STALL_CNT_EN
    logic [CW-1:0] r_stall_cnt;

    // Saturating count of stalled cycles since reset
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
        end else if (stall_m_o && (r_stall_cnt != {CW{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_memory_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_stage_pipe
// Brief    : Directed self-checking bench for memory_stage_pipe (DW=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_stage_pipe;

    localparam int DW = 32;
    localparam int RW = 5;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            valid_m_i;
    logic            reg_write_m_i;
    logic            mem_to_reg_m_i;
    logic            mem_read_m_i;
    logic            mem_write_m_i;
    logic [1:0]      mem_size_m_i;
    logic            mem_unsigned_m_i;
    logic [DW-1:0]   alu_out_m_i;
    logic [DW-1:0]   write_data_m_i;
    logic [RW-1:0]   write_reg_m_i;
    logic            flush_m_i;
    logic            dmem_req_o;
    logic            dmem_we_o;
    logic [DW-1:0]   dmem_addr_o;
    logic [DW-1:0]   dmem_wdata_o;
    logic [DW/8-1:0] dmem_be_o;
    logic            dmem_ack_i;
    logic [DW-1:0]   dmem_rdata_i;
    logic            stall_m_o;
    logic            misalign_o;
    logic            valid_w_o;
    logic            reg_write_w_o;
    logic            mem_to_reg_w_o;
    logic [DW-1:0]   alu_out_w_o;
    logic [DW-1:0]   read_data_w_o;
    logic [RW-1:0]   write_reg_w_o;
`ifdef MEM_STAGE_STALL_CNT_EN
    logic [15:0]     stall_cnt_o;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk_i = ~clk_i;

    memory_stage_pipe #(.DW(DW), .RW(RW)) u_dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .valid_m_i        (valid_m_i),
        .reg_write_m_i    (reg_write_m_i),
        .mem_to_reg_m_i   (mem_to_reg_m_i),
        .mem_read_m_i     (mem_read_m_i),
        .mem_write_m_i    (mem_write_m_i),
        .mem_size_m_i     (mem_size_m_i),
        .mem_unsigned_m_i (mem_unsigned_m_i),
        .alu_out_m_i      (alu_out_m_i),
        .write_data_m_i   (write_data_m_i),
        .write_reg_m_i    (write_reg_m_i),
        .flush_m_i        (flush_m_i),
        .dmem_req_o       (dmem_req_o),
        .dmem_we_o        (dmem_we_o),
        .dmem_addr_o      (dmem_addr_o),
        .dmem_wdata_o     (dmem_wdata_o),
        .dmem_be_o        (dmem_be_o),
        .dmem_ack_i       (dmem_ack_i),
        .dmem_rdata_i     (dmem_rdata_i),
        .stall_m_o        (stall_m_o),
        .misalign_o       (misalign_o),
        .valid_w_o        (valid_w_o),
        .reg_write_w_o    (reg_write_w_o),
        .mem_to_reg_w_o   (mem_to_reg_w_o),
        .alu_out_w_o      (alu_out_w_o),
        .read_data_w_o    (read_data_w_o),
        .write_reg_w_o    (write_reg_w_o)
`ifdef MEM_STAGE_STALL_CNT_EN
        ,
        .stall_cnt_o      (stall_cnt_o)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic v, input logic rw, input logic m2r,
                          input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [DW-1:0] alu,
                          input logic [DW-1:0] wd, input logic [RW-1:0] wreg);
        valid_m_i        = v;
        reg_write_m_i    = rw;
        mem_to_reg_m_i   = m2r;
        mem_read_m_i     = rd;
        mem_write_m_i    = wr;
        mem_size_m_i     = sz;
        mem_unsigned_m_i = uns;
        alu_out_m_i      = alu;
        write_data_m_i   = wd;
        write_reg_m_i    = wreg;
    endtask

    task automatic go_idle();
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, '0, '0, '0);
        flush_m_i  = 1'b0;
        dmem_ack_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i        = 1'b0;
        dmem_rdata_i = '0;
        go_idle();
        #2;
        chk("rst_valid_w", valid_w_o, 1'b0);
        chk("rst_req", dmem_req_o, 1'b0);
        chk("rst_stall", stall_m_o, 1'b0);
        chk("rst_misalign", misalign_o, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // ALU op passes straight through
        @(negedge clk_i);
        set_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 32'h1234, 32'h0, 5'd7);
        #1;
        chk("alu_req", dmem_req_o, 1'b0);
        chk("alu_stall", stall_m_o, 1'b0);
        tick();
        chk("alu_valid_w", valid_w_o, 1'b1);
        chk("alu_regw_w", reg_write_w_o, 1'b1);
        chk("alu_out_w", alu_out_w_o, 32'h1234);
        chk("alu_wreg_w", write_reg_w_o, 5'd7);
        @(negedge clk_i);
        go_idle();
        tick();
        chk("idle_valid_w", valid_w_o, 1'b0);

        // Signed byte load at 0x103, ack after two wait cycles
        @(negedge clk_i);
        set_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 5'd3);
        #1;
        chk("lb_req0", dmem_req_o, 1'b1);
        chk("lb_stall0", stall_m_o, 1'b1);
        chk("lb_addr", dmem_addr_o, 32'h100);
        chk("lb_we", dmem_we_o, 1'b0);
        chk("lb_be", dmem_be_o, 4'b1000);
        tick();
        chk("lb_bubble0", valid_w_o, 1'b0);
        @(negedge clk_i);
        #1;
        chk("lb_stall1", stall_m_o, 1'b1);
        chk("lb_req1", dmem_req_o, 1'b1);
        tick();
        chk("lb_bubble1", valid_w_o, 1'b0);
        @(negedge clk_i);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'h80123456;
        #1;
        chk("lb_stall_ack", stall_m_o, 1'b0);
        chk("lb_req_ack", dmem_req_o, 1'b1);
        tick();
        chk("lb_valid_w", valid_w_o, 1'b1);
        chk("lb_rdata_w", read_data_w_o, 32'hFFFFFF80);
        chk("lb_alu_w", alu_out_w_o, 32'h103);
        chk("lb_m2r_w", mem_to_reg_w_o, 1'b1);
        chk("lb_wreg_w", write_reg_w_o, 5'd3);

        // Unsigned byte load, same-cycle ack
        @(negedge clk_i);
        set_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 5'd4);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'h80000000;
        #1;
        chk("lbu_stall", stall_m_o, 1'b0);
        chk("lbu_req", dmem_req_o, 1'b1);
        tick();
        chk("lbu_valid_w", valid_w_o, 1'b1);
        chk("lbu_rdata_w", read_data_w_o, 32'h00000080);

        // Signed half load at 0x102, same-cycle ack
        @(negedge clk_i);
        set_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 5'd5);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'h9ABC0000;
        #1;
        chk("lh_be", dmem_be_o, 4'b1100);
        tick();
        chk("lh_rdata_w", read_data_w_o, 32'hFFFF9ABC);

        // Half store at 0x202, same-cycle ack
        @(negedge clk_i);
        set_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, 5'd0);
        dmem_ack_i = 1'b1;
        #1;
        chk("sh_be", dmem_be_o, 4'b1100);
        chk("sh_wdata", dmem_wdata_o, 32'hABCDABCD);
        chk("sh_we", dmem_we_o, 1'b1);
        chk("sh_addr", dmem_addr_o, 32'h200);
        chk("sh_stall", stall_m_o, 1'b0);
        tick();
        chk("sh_valid_w", valid_w_o, 1'b1);
        chk("sh_regw_w", reg_write_w_o, 1'b0);

        // Byte store at 0x201
        @(negedge clk_i);
        set_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h201, 32'h0000005A, 5'd0);
        dmem_ack_i = 1'b1;
        #1;
        chk("sb_be", dmem_be_o, 4'b0010);
        chk("sb_wdata", dmem_wdata_o, 32'h5A5A5A5A);
        tick();

        // Misaligned word load at 0x101
        @(negedge clk_i);
        set_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 5'd6);
        dmem_ack_i = 1'b0;
        #1;
        chk("mis_req", dmem_req_o, 1'b0);
        chk("mis_stall", stall_m_o, 1'b0);
        tick();
        chk("mis_bubble", valid_w_o, 1'b0);
        chk("mis_pulse", misalign_o, 1'b1);
        @(negedge clk_i);
        go_idle();
        tick();
        chk("mis_pulse_end", misalign_o, 1'b0);

        // Flush while waiting: request stays up, result dropped
        @(negedge clk_i);
        set_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 5'd9);
        #1;
        chk("fl_stall0", stall_m_o, 1'b1);
        tick();
        @(negedge clk_i);
        flush_m_i = 1'b1;
        #1;
        chk("fl_req_flush", dmem_req_o, 1'b1);
        chk("fl_stall_flush", stall_m_o, 1'b1);
        tick();
        chk("fl_bubble0", valid_w_o, 1'b0);
        @(negedge clk_i);
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'hDEAD0000, 32'h0, 5'd0);
        flush_m_i = 1'b0;
        #1;
        chk("fl_req_hold", dmem_req_o, 1'b1);
        chk("fl_addr_hold", dmem_addr_o, 32'h300);
        tick();
        @(negedge clk_i);
        #1;
        chk("fl_req_hold2", dmem_req_o, 1'b1);
        tick();
        @(negedge clk_i);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'h11223344;
        #1;
        chk("fl_req_ack", dmem_req_o, 1'b1);
        chk("fl_stall_ack", stall_m_o, 1'b0);
        tick();
        chk("fl_dropped", valid_w_o, 1'b0);
        @(negedge clk_i);
        dmem_ack_i = 1'b0;
        #1;
        chk("fl_back_idle", dmem_req_o, 1'b0);

        // Reset asserted mid-WAIT
        @(negedge clk_i);
        set_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 5'd10);
        tick();
        @(negedge clk_i);
        #1;
        chk("rw_req_before", dmem_req_o, 1'b1);
        #2;
        rst_i = 1'b0;
        #1;
        chk("rw_req_async", dmem_req_o, 1'b0);
        chk("rw_stall_async", stall_m_o, 1'b0);
        #1;
        go_idle();
        dmem_ack_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("rw_late_ack_req", dmem_req_o, 1'b0);
        tick();
        chk("rw_late_ack_w", valid_w_o, 1'b0);
`ifdef MEM_STAGE_STALL_CNT_EN
        chk("cnt_after_rst", stall_cnt_o, 16'd0);
`endif

        // Five stall cycles, then completion
        @(negedge clk_i);
        set_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h500, 32'h0, 5'd11);
        dmem_ack_i = 1'b0;
        #1;
        chk("s5_stall0", stall_m_o, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk_i);
            #1;
            chk("s5_stall_wait", stall_m_o, 1'b1);
        end
        tick();
        @(negedge clk_i);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'hCAFEBABE;
        #1;
        chk("s5_stall_ack", stall_m_o, 1'b0);
        tick();
        chk("s5_valid_w", valid_w_o, 1'b1);
        chk("s5_rdata_w", read_data_w_o, 32'hCAFEBABE);
`ifdef MEM_STAGE_STALL_CNT_EN
        chk("cnt_five", stall_cnt_o, 16'd5);
`endif
        @(negedge clk_i);
        go_idle();
        rst_i = 1'b0;
        #1;
        chk("rst2_valid_w", valid_w_o, 1'b0);
`ifdef MEM_STAGE_STALL_CNT_EN
        chk("cnt_cleared", stall_cnt_o, 16'd0);
`endif
        @(negedge clk_i);
        rst_i = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
